// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle RV32I control sequencer with memory handshake, traps and retire counter
module multicycle_control #(
    parameter int MEM_TIMEOUT = 16,
    parameter bit SUPPORT_EXT = 1'b1,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           opcode,
    input  logic                 mem_ready,
    input  logic                 stall,
    input  logic                 trap_clear,
    output logic                 branch,
    output logic                 memRead,
    output logic                 memToReg,
    output logic                 memWrite,
    output logic                 ALUSrc,
    output logic                 regWrite,
    output logic [1:0]           ALUOp,
    output logic                 mem_req,
    output logic                 iord,
    output logic                 ir_write,
    output logic                 pc_inc,
    output logic                 pc_write,
    output logic [2:0]           state,
    output logic                 trap,
    output logic [1:0]           trap_cause,
    output logic [CNT_WIDTH-1:0] retired
);
    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        MEM       = 3'd3,
        WRITEBACK = 3'd4,
        TRAP      = 3'd5
    } state_t;

    localparam int WW = MEM_TIMEOUT > 0 ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_IA    = 7'b0010011;
    localparam logic [6:0] OP_IL    = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_J     = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    state_t                 state_q, state_d;
    logic [6:0]             opcode_q, opcode_d;
    logic [WW-1:0]          wait_q, wait_d;
    logic [1:0]             trap_cause_q, trap_cause_d;
    logic [CNT_WIDTH-1:0]   retired_q, retired_d;
    logic                   retire, timeout;
    logic                   is_r, is_il, is_s, is_b, is_j, is_jalr;
    logic                   alu_src;
    logic [1:0]             alu_op;

    function automatic logic legal(input logic [6:0] op);
        return (op inside {OP_R, OP_IA, OP_IL, OP_S, OP_B, OP_J}) ||
               (SUPPORT_EXT && (op inside {OP_LUI, OP_AUIPC, OP_JALR}));
    endfunction

    assign is_r    = opcode_q == OP_R;
    assign is_il   = opcode_q == OP_IL;
    assign is_s    = opcode_q == OP_S;
    assign is_b    = opcode_q == OP_B;
    assign is_j    = opcode_q == OP_J;
    assign is_jalr = opcode_q == OP_JALR;
    assign alu_src = !(is_r || is_b || is_j);
    assign alu_op  = is_b ? 2'b01 : (is_il || is_s) ? 2'b00 : (is_j || is_jalr) ? 2'b11 : 2'b10;
    assign timeout = (MEM_TIMEOUT != 0) && !mem_ready && (wait_q == WW'(MEM_TIMEOUT));

    assign state      = state_q;
    assign trap_cause = trap_cause_q;
    assign retired    = retired_q;

    // Next state, strobes and bookkeeping; everything is held at zero while rst is high
    always_comb begin
        state_d      = state_q;
        trap_cause_d = trap_cause_q;
        retire       = 1'b0;
        branch       = 1'b0;
        memRead      = 1'b0;
        memToReg     = 1'b0;
        memWrite     = 1'b0;
        ALUSrc       = 1'b0;
        regWrite     = 1'b0;
        ALUOp        = 2'b00;
        mem_req      = 1'b0;
        iord         = 1'b0;
        ir_write     = 1'b0;
        pc_inc       = 1'b0;
        pc_write     = 1'b0;
        trap         = 1'b0;
        if (!rst) begin
            case (state_q)
                FETCH: begin
                    mem_req  = 1'b1;
                    ir_write = mem_ready;
                    pc_inc   = mem_ready;
                    if (mem_ready) state_d = DECODE;
                    else if (timeout) begin
                        state_d      = TRAP;
                        trap_cause_d = 2'b10;
                    end
                end
                DECODE: begin
                    if (!stall && !legal(opcode)) begin
                        state_d      = TRAP;
                        trap_cause_d = 2'b01;
                    end else if (!stall) state_d = EXECUTE;
                end
                EXECUTE: begin
                    ALUSrc   = alu_src;
                    ALUOp    = alu_op;
                    branch   = is_b && !stall;
                    pc_write = (is_j || is_jalr) && !stall;
                    if (!stall) begin
                        state_d = is_b ? FETCH : (is_il || is_s) ? MEM : WRITEBACK;
                        retire  = is_b;
                    end
                end
                MEM: begin
                    mem_req  = 1'b1;
                    iord     = 1'b1;
                    memRead  = is_il;
                    memWrite = is_s;
                    ALUSrc   = alu_src;
                    ALUOp    = alu_op;
                    if (mem_ready) begin
                        state_d = is_s ? FETCH : WRITEBACK;
                        retire  = is_s;
                    end else if (timeout) begin
                        state_d      = TRAP;
                        trap_cause_d = 2'b10;
                    end
                end
                WRITEBACK: begin
                    regWrite = !stall;
                    memToReg = is_il;
                    if (!stall) begin
                        state_d = FETCH;
                        retire  = 1'b1;
                    end
                end
                TRAP: begin
                    trap = 1'b1;
                    if (trap_clear) begin
                        state_d      = FETCH;
                        trap_cause_d = 2'b00;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
        opcode_d  = state_q == DECODE ? opcode : opcode_q;
        wait_d    = (state_d != state_q || mem_ready) ? '0 : (mem_req ? wait_q + WW'(1) : wait_q);
        retired_d = retire ? retired_q + CNT_WIDTH'(1) : retired_q;
    end

    // State, latched opcode, wait counter, trap cause and retire count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= FETCH;
            opcode_q     <= '0;
            wait_q       <= '0;
            trap_cause_q <= '0;
            retired_q    <= '0;
        end else begin
            state_q      <= state_d;
            opcode_q     <= opcode_d;
            wait_q       <= wait_d;
            trap_cause_q <= trap_cause_d;
            retired_q    <= retired_d;
        end
    end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed checks of the multi-cycle control sequencer
module tb_multicycle_control;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [6:0] opcode = '0;
    logic mem_ready = 1'b0, stall = 1'b0, trap_clear = 1'b0;
    int errors = 0;
    int checks = 0;

    logic a_branch, a_memRead, a_memToReg, a_memWrite, a_ALUSrc, a_regWrite;
    logic [1:0] a_ALUOp, a_trap_cause;
    logic a_mem_req, a_iord, a_ir_write, a_pc_inc, a_pc_write, a_trap;
    logic [2:0] a_state;
    logic [3:0] a_retired;
    logic b_branch, b_memRead, b_memToReg, b_memWrite, b_ALUSrc, b_regWrite;
    logic [1:0] b_ALUOp, b_trap_cause;
    logic b_mem_req, b_iord, b_ir_write, b_pc_inc, b_pc_write, b_trap;
    logic [2:0] b_state;
    logic [31:0] b_retired;

    localparam logic [6:0] OP_R = 7'b0110011, OP_IL = 7'b0000011, OP_S = 7'b0100011;
    localparam logic [6:0] OP_B = 7'b1100011, OP_J = 7'b1101111, OP_LUI = 7'b0110111;

    always #5 clk = ~clk;

    multicycle_control #(.MEM_TIMEOUT(4), .SUPPORT_EXT(1'b1), .CNT_WIDTH(4)) dut_a (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready), .stall(stall),
        .trap_clear(trap_clear), .branch(a_branch), .memRead(a_memRead), .memToReg(a_memToReg),
        .memWrite(a_memWrite), .ALUSrc(a_ALUSrc), .regWrite(a_regWrite), .ALUOp(a_ALUOp),
        .mem_req(a_mem_req), .iord(a_iord), .ir_write(a_ir_write), .pc_inc(a_pc_inc),
        .pc_write(a_pc_write), .state(a_state), .trap(a_trap), .trap_cause(a_trap_cause),
        .retired(a_retired)
    );

    multicycle_control #(.MEM_TIMEOUT(16), .SUPPORT_EXT(1'b0), .CNT_WIDTH(32)) dut_b (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready), .stall(stall),
        .trap_clear(trap_clear), .branch(b_branch), .memRead(b_memRead), .memToReg(b_memToReg),
        .memWrite(b_memWrite), .ALUSrc(b_ALUSrc), .regWrite(b_regWrite), .ALUOp(b_ALUOp),
        .mem_req(b_mem_req), .iord(b_iord), .ir_write(b_ir_write), .pc_inc(b_pc_inc),
        .pc_write(b_pc_write), .state(b_state), .trap(b_trap), .trap_cause(b_trap_cause),
        .retired(b_retired)
    );

    // Leaves the bench at the negedge of the first cycle after reset release
    task automatic reset_dut();
        rst = 1'b1; stall = 1'b0; trap_clear = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_ready = 1'b1; opcode = OP_R;
        @(negedge clk); #3;
        checks++; if ({a_mem_req, a_ir_write, a_pc_inc, a_trap} !== 4'b0000) begin errors++; $display("FAIL reset_strobes got=%b exp=0000", {a_mem_req, a_ir_write, a_pc_inc, a_trap}); end
        checks++; if (a_state !== 3'd0 || a_retired !== 4'd0 || a_trap_cause !== 2'b00) begin errors++; $display("FAIL reset_regs state=%0d retired=%0d cause=%b", a_state, a_retired, a_trap_cause); end
        @(negedge clk); rst = 1'b0; #3;
        checks++; if ({a_mem_req, a_iord, a_ir_write} !== 3'b101) begin errors++; $display("FAIL first_fetch got=%b exp=101", {a_mem_req, a_iord, a_ir_write}); end
    endtask

    task automatic test_r_type();
        logic [2:0] exp_st [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0};
        reset_dut(); mem_ready = 1'b1; opcode = OP_R;
        for (int c = 0; c < 5; c++) begin
            #3;
            checks++; if (a_state !== exp_st[c]) begin errors++; $display("FAIL r_state c%0d got=%0d exp=%0d", c + 1, a_state, exp_st[c]); end
            if (c == 0) begin checks++; if ({a_ir_write, a_pc_inc} !== 2'b11) begin errors++; $display("FAIL r_fetch got=%b exp=11", {a_ir_write, a_pc_inc}); end end
            if (c == 1) begin checks++; if ({a_ir_write, a_mem_req} !== 2'b00) begin errors++; $display("FAIL r_decode got=%b exp=00", {a_ir_write, a_mem_req}); end end
            if (c == 2) begin checks++; if ({a_ALUOp, a_ALUSrc, a_regWrite} !== 4'b1000) begin errors++; $display("FAIL r_exec got=%b exp=1000", {a_ALUOp, a_ALUSrc, a_regWrite}); end end
            if (c == 3) begin checks++; if ({a_regWrite, a_memToReg, a_ALUOp} !== 4'b1000) begin errors++; $display("FAIL r_wb got=%b exp=1000", {a_regWrite, a_memToReg, a_ALUOp}); end end
            @(negedge clk);
        end
        #3;
        checks++; if (a_retired !== 4'd1 || b_retired !== 32'd1) begin errors++; $display("FAIL r_retired got=%0d/%0d exp=1", a_retired, b_retired); end
    endtask

    task automatic test_load();
        reset_dut(); mem_ready = 1'b1; opcode = OP_IL;
        @(negedge clk); @(negedge clk); #3;
        checks++; if ({a_state, a_ALUSrc, a_ALUOp} !== 6'b010_1_00) begin errors++; $display("FAIL ld_exec got=%b exp=010100", {a_state, a_ALUSrc, a_ALUOp}); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); mem_ready = (k == 2); #3;
            checks++; if ({a_state, a_memRead, a_iord, a_mem_req, a_memWrite} !== 7'b011_1110) begin errors++; $display("FAIL ld_mem k%0d got=%b exp=0111110", k, {a_state, a_memRead, a_iord, a_mem_req, a_memWrite}); end
        end
        @(negedge clk); #3;
        checks++; if ({a_state, a_regWrite, a_memToReg} !== 5'b100_11) begin errors++; $display("FAIL ld_wb got=%b exp=10011", {a_state, a_regWrite, a_memToReg}); end
        @(negedge clk); #3;
        checks++; if (a_state !== 3'd0 || a_retired !== 4'd1) begin errors++; $display("FAIL ld_done state=%0d retired=%0d exp 0/1", a_state, a_retired); end
    endtask

    task automatic test_store();
        reset_dut(); mem_ready = 1'b1; opcode = OP_S;
        @(negedge clk); @(negedge clk); @(negedge clk); #3;
        checks++; if ({a_state, a_memWrite, a_memRead, a_ALUSrc, a_ALUOp} !== 8'b011_10_1_00) begin errors++; $display("FAIL st_mem got=%b exp=01110100", {a_state, a_memWrite, a_memRead, a_ALUSrc, a_ALUOp}); end
        @(negedge clk); #3;
        checks++; if (a_state !== 3'd0 || a_retired !== 4'd1) begin errors++; $display("FAIL st_done state=%0d retired=%0d exp 0/1", a_state, a_retired); end
    endtask

    task automatic test_illegal();
        reset_dut(); mem_ready = 1'b1; opcode = 7'b1111111;
        @(negedge clk); @(negedge clk);
        stall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            trap_clear = (k == 4); #3;
            checks++; if ({a_state, a_trap, a_trap_cause, a_mem_req, a_ir_write} !== 8'b101_1_01_00) begin errors++; $display("FAIL ill_trap k%0d got=%b exp=10110100", k, {a_state, a_trap, a_trap_cause, a_mem_req, a_ir_write}); end
            @(negedge clk);
        end
        trap_clear = 1'b0; stall = 1'b0; #3;
        checks++; if ({a_state, a_trap, a_trap_cause} !== 6'b000_0_00) begin errors++; $display("FAIL ill_clear got=%b exp=000000", {a_state, a_trap, a_trap_cause}); end
    endtask

    task automatic test_timeout();
        reset_dut(); mem_ready = 1'b0; opcode = OP_R;
        for (int k = 0; k < 5; k++) begin
            #3;
            checks++; if ({a_state, a_mem_req, a_ir_write} !== 5'b000_10) begin errors++; $display("FAIL to_wait k%0d got=%b exp=00010", k, {a_state, a_mem_req, a_ir_write}); end
            @(negedge clk);
        end
        #3;
        checks++; if (a_state !== 3'd5 || a_trap_cause !== 2'b10) begin errors++; $display("FAIL to_trap state=%0d cause=%b exp 5/10", a_state, a_trap_cause); end
        checks++; if (b_state !== 3'd0) begin errors++; $display("FAIL to_long state=%0d exp=0", b_state); end
        reset_dut(); mem_ready = 1'b0;
        for (int k = 0; k < 4; k++) @(negedge clk);
        mem_ready = 1'b1; #3;
        checks++; if (a_ir_write !== 1'b1) begin errors++; $display("FAIL to_edge_irw got=%b exp=1", a_ir_write); end
        @(negedge clk); #3;
        checks++; if (a_state !== 3'd1 || a_trap !== 1'b0) begin errors++; $display("FAIL to_edge state=%0d trap=%b exp 1/0", a_state, a_trap); end
    endtask

    task automatic test_jump_stall();
        reset_dut(); mem_ready = 1'b1; opcode = OP_J;
        @(negedge clk); @(negedge clk);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #3;
            checks++; if ({a_state, a_pc_write} !== 4'b010_0) begin errors++; $display("FAIL j_stall k%0d got=%b exp=0100", k, {a_state, a_pc_write}); end
            @(negedge clk);
        end
        stall = 1'b0; #3;
        checks++; if ({a_state, a_pc_write, a_ALUOp, a_ALUSrc} !== 7'b010_1_11_0) begin errors++; $display("FAIL j_exec got=%b exp=0101110", {a_state, a_pc_write, a_ALUOp, a_ALUSrc}); end
        @(negedge clk); #3;
        checks++; if ({a_state, a_regWrite, a_pc_write} !== 5'b100_10) begin errors++; $display("FAIL j_wb got=%b exp=10010", {a_state, a_regWrite, a_pc_write}); end
    endtask

    task automatic test_ext();
        reset_dut(); mem_ready = 1'b1; opcode = OP_LUI;
        @(negedge clk); @(negedge clk); #3;
        checks++; if ({a_state, a_ALUSrc, a_ALUOp} !== 6'b010_1_10) begin errors++; $display("FAIL lui_ext got=%b exp=010110", {a_state, a_ALUSrc, a_ALUOp}); end
        checks++; if (b_state !== 3'd5 || b_trap_cause !== 2'b01) begin errors++; $display("FAIL lui_noext state=%0d cause=%b exp 5/01", b_state, b_trap_cause); end
    endtask

    task automatic test_abort();
        reset_dut(); mem_ready = 1'b1; opcode = OP_R;
        @(negedge clk); @(negedge clk); @(negedge clk);
        rst = 1'b1; #3;
        checks++; if ({a_state, a_regWrite, a_retired} !== 11'b0) begin errors++; $display("FAIL abort got=%b exp=0", {a_state, a_regWrite, a_retired}); end
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        reset_dut(); mem_ready = 1'b1; opcode = OP_B;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk); @(negedge clk); #3;
            if (k == 0) begin checks++; if ({a_state, a_branch, a_ALUOp, a_ALUSrc} !== 7'b010_1_01_0) begin errors++; $display("FAIL b_exec got=%b exp=0101010", {a_state, a_branch, a_ALUOp, a_ALUSrc}); end end
            @(negedge clk);
        end
        #3;
        checks++; if (a_retired !== 4'd0 || b_retired !== 32'd16) begin errors++; $display("FAIL wrap got=%0d/%0d exp 0/16", a_retired, b_retired); end
    endtask

    initial begin
        test_reset();
        test_r_type();
        test_load();
        test_store();
        test_illegal();
        test_timeout();
        test_jump_stall();
        test_ext();
        test_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
